// File: rtl/fpnew_multi_hart_sched_pkg.sv
// Shared types for the multi-hart FPU scheduler: operation request and
// response records as seen by fpnew_top, arbiter states and a wrap helper.
package fpnew_multi_hart_sched_pkg;

  localparam int unsigned WIDTH        = 64;
  localparam int unsigned NUM_OPERANDS = 3;

  // Requester-local tag, passed through the FPU untouched.
  typedef logic [3:0] tag_t;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef enum logic [2:0] {FP32, FP64, FP16, FP8, FP16ALT} fp_format_e;
  typedef enum logic [1:0] {INT8, INT16, INT32, INT64} int_format_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  typedef struct packed {
    logic [NUM_OPERANDS-1:0][WIDTH-1:0] operands;
    roundmode_e                         rnd_mode;
    operation_e                         op;
    logic                               op_mod;
    fp_format_e                         src_fmt;
    fp_format_e                         dst_fmt;
    int_format_e                        int_fmt;
    logic                               vectorial;
    tag_t                               tag;
  } fpu_req_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    status_t          status;
    tag_t             tag;
  } fpu_rsp_t;

  // Issue-side arbiter: free to pick a new winner, or holding a stalled grant.
  typedef enum logic {
    ARB_FREE,
    ARB_LOCKED
  } arb_state_e;

  // Single conditional subtract: idx is known to be below 2*n.
  function automatic int unsigned wrap_idx(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/fpnew_credit_cnt.sv
// Per-requester outstanding-operation counter. Increments on issue,
// decrements on response, holds when both happen together, saturates at
// MaxVal, never underflows, and clears on flush.
module fpnew_credit_cnt #(
  parameter int unsigned MaxVal = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned CntW = $clog2(MaxVal + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, simultaneous inc/dec cancel, bounds are held.
  always_comb begin
    // NOTE: cnt_d gets its default before any branch, so every path assigns it and no latch is inferred.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i && !full_o) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (dec_i && !inc_i && !empty_o) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign full_o  = (cnt_q == CntW'(MaxVal));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fpnew_multi_hart_sched.sv
// Shares one fpnew_top between NumReq requesters. Round-robin issue with a
// grant lock while the FPU stalls, per-requester credit limits, FPU tag
// extended with the requester index, and responses routed back by that index.
module fpnew_multi_hart_sched
  import fpnew_multi_hart_sched_pkg::*;
#(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned Width    = WIDTH,
  parameter int unsigned MaxOutst = 4,
  parameter type         TagType  = tag_t
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   flush_i,
  input  logic [NumReq-1:0]                      req_valid_i,
  output logic [NumReq-1:0]                      req_ready_o,
  input  fpu_req_t [NumReq-1:0]                  req_i,
  output logic [NumReq-1:0]                      rsp_valid_o,
  input  logic [NumReq-1:0]                      rsp_ready_i,
  output fpu_rsp_t                               rsp_o,
  output logic                                   fpu_valid_o,
  input  logic                                   fpu_ready_i,
  output fpu_req_t                               fpu_req_o,
  output logic [$clog2(NumReq)+$bits(TagType)-1:0] fpu_tag_o,
  output logic                                   fpu_flush_o,
  input  logic                                   fpu_rsp_valid_i,
  output logic                                   fpu_rsp_ready_o,
  input  logic [Width+$bits(status_t)+$clog2(NumReq)+$bits(TagType)-1:0] fpu_rsp_i,
  output logic                                   busy_o
);

  localparam int unsigned IdxW = $clog2(NumReq);

  typedef struct packed {
    logic [IdxW-1:0] idx;
    TagType          tag;
  } sched_tag_t;

  // What fpnew_top hands back: result, flags and the extended tag.
  typedef struct packed {
    logic [Width-1:0] result;
    status_t          status;
    sched_tag_t       tag;
  } fpu_out_t;

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;

  logic [NumReq-1:0] eligible, full, empty, rsp_hs;
  logic [IdxW-1:0]   rr_idx, gnt_idx;
  logic              any_elig, issue_hs, rsp_idx_ok;
  fpu_out_t          fpu_out;
  sched_tag_t        issue_tag;

  assign eligible = req_valid_i & ~full;
  assign fpu_out  = fpu_rsp_i;

  // Round-robin search: first eligible requester at or after the pointer.
  always_comb begin
    rr_idx   = '0;
    any_elig = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!any_elig && eligible[IdxW'(wrap_idx(32'(ptr_q) + k, NumReq))]) begin
        any_elig = 1'b1;
        rr_idx   = IdxW'(wrap_idx(32'(ptr_q) + k, NumReq));
      end
    end
  end

  // A stalled grant stays with its requester so the FPU sees stable data.
  assign gnt_idx   = (state_q == ARB_LOCKED) ? lock_idx_q : rr_idx;
  assign issue_tag = '{idx: gnt_idx, tag: TagType'(req_i[gnt_idx].tag)};

  // Issue-side outputs; flush suppresses any issue this cycle.
  always_comb begin
    fpu_valid_o = ((state_q == ARB_LOCKED) || any_elig) && !flush_i;
    issue_hs    = fpu_valid_o && fpu_ready_i;
    req_ready_o = '0;
    if (issue_hs) begin
      req_ready_o[gnt_idx] = 1'b1;
    end
  end

  // The op record keeps its local tag; the FPU carries the extended tag.
  assign fpu_req_o   = req_i[gnt_idx];
  assign fpu_tag_o   = issue_tag;
  assign fpu_flush_o = flush_i;

  // Arbiter next state: flush resets, handshake advances, stall locks.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_idx_d = lock_idx_q;
    if (flush_i) begin
      state_d = ARB_FREE;
      ptr_d   = '0;
    end else if (issue_hs) begin
      state_d = ARB_FREE;
      ptr_d   = IdxW'(wrap_idx(32'(gnt_idx) + 32'd1, NumReq));
    end else if (fpu_valid_o) begin
      state_d    = ARB_LOCKED;
      lock_idx_d = gnt_idx;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB_FREE;
      ptr_q      <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // Response routing by the index half of the tag; flush drains the FPU.
  assign rsp_idx_ok = (32'(fpu_out.tag.idx) < NumReq);

  always_comb begin
    rsp_valid_o     = '0;
    fpu_rsp_ready_o = flush_i;
    if (!flush_i && rsp_idx_ok) begin
      rsp_valid_o[fpu_out.tag.idx] = fpu_rsp_valid_i;
      fpu_rsp_ready_o              = rsp_ready_i[fpu_out.tag.idx];
    end
  end

  assign rsp_hs = rsp_valid_o & rsp_ready_i;
  assign rsp_o  = '{result: fpu_out.result, status: fpu_out.status, tag: tag_t'(fpu_out.tag.tag)};

  for (genvar i = 0; i < NumReq; i++) begin : g_credit
    fpnew_credit_cnt #(
      .MaxVal (MaxOutst)
    ) i_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (flush_i),
      .inc_i   (req_ready_o[i]),
      .dec_i   (rsp_hs[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );
  end

  assign busy_o = (|(~empty)) || fpu_valid_o;

`ifndef SYNTHESIS
  // A response for a requester with nothing outstanding is a protocol error.
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(|(rsp_hs & empty)))
    else $error("response routed to requester with no outstanding op");
  a_one_ready: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(req_ready_o))
    else $error("more than one req_ready_o asserted");
  a_ready_needs_fpu: assert property (@(posedge clk_i) disable iff (!rst_ni) (|req_ready_o) |-> fpu_ready_i)
    else $error("req_ready_o without fpu_ready_i");
`endif

endmodule

// File: tb/tb_fpnew_multi_hart_sched.sv
// Randomised bench for the multi-hart FPU scheduler. A behavioural model
// (credit counts, rotating priority, held grant, in-order FPU queue) predicts
// every output each cycle.
module tb_fpnew_multi_hart_sched;
  import fpnew_multi_hart_sched_pkg::*;

  localparam int N    = 4;
  localparam int MAXO = 4;
  localparam int IW   = 2;
  localparam int TW   = IW + 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  fpu_req_t [N-1:0] req;
  fpu_rsp_t rsp;
  logic fpu_valid, fpu_ready, fpu_flush, fpu_rsp_valid, fpu_rsp_ready, busy, flush;
  fpu_req_t fpu_req;
  logic [TW-1:0] fpu_tag;
  logic [WIDTH-1:0] out_res;
  status_t out_st;
  logic [TW-1:0] out_tag;
  logic [WIDTH+$bits(status_t)+TW-1:0] fpu_rsp;
  assign fpu_rsp = {out_res, out_st, out_tag};

  fpnew_multi_hart_sched #(
    .NumReq(N), .Width(WIDTH), .MaxOutst(MAXO), .TagType(tag_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_i(req),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_o(rsp),
    .fpu_valid_o(fpu_valid), .fpu_ready_i(fpu_ready), .fpu_req_o(fpu_req),
    .fpu_tag_o(fpu_tag), .fpu_flush_o(fpu_flush),
    .fpu_rsp_valid_i(fpu_rsp_valid), .fpu_rsp_ready_o(fpu_rsp_ready),
    .fpu_rsp_i(fpu_rsp), .busy_o(busy)
  );

  // Reference model state.
  int cnt[N];
  int ptr;
  bit locked;
  int lock_idx;
  bit done[N];
  logic [TW-1:0] fq[$];
  bit shown;

  int n_checks = 0;
  int n_err    = 0;
  int p_req, p_rdy, p_rsp, p_rsp_rdy, p_flush;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  function automatic fpu_req_t rand_req();
    logic [223:0] raw;
    raw = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return fpu_req_t'(raw[$bits(fpu_req_t)-1:0]);
  endfunction

  function automatic bit chance(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    ptr = 0;
    locked = 0;
    lock_idx = 0;
    fq.delete();
    shown = 0;
  endfunction

  // Compare every output at the falling edge, then advance the model.
  task automatic step();
    int g, ridx;
    bit v, hs, rhs, efr, ebusy;
    logic [N-1:0] erdy, erv;
    @(negedge clk);
    v = 0;
    g = 0;
    if (locked) begin
      v = 1;
      g = lock_idx;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!v && req_valid[(ptr + k) % N] && cnt[(ptr + k) % N] < MAXO) begin
          v = 1;
          g = (ptr + k) % N;
        end
      end
    end
    if (flush) v = 0;
    hs = v && fpu_ready;
    erdy = '0;
    if (hs) erdy[g] = 1'b1;
    check("fpu_valid", 256'(fpu_valid), 256'(v));
    check("req_ready", 256'(req_ready), 256'(erdy));
    check("fpu_flush", 256'(fpu_flush), 256'(flush));
    if (v) begin
      check("fpu_tag", 256'(fpu_tag), 256'({IW'(g), req[g].tag}));
      check("fpu_req", 256'(fpu_req), 256'(req[g]));
    end

    ridx = int'(out_tag[TW-1:TW-IW]);
    erv  = '0;
    efr  = 1'b1;
    if (!flush) begin
      efr = rsp_ready[ridx];
      if (fpu_rsp_valid) erv[ridx] = 1'b1;
    end
    check("rsp_valid", 256'(rsp_valid), 256'(erv));
    check("fpu_rsp_ready", 256'(fpu_rsp_ready), 256'(efr));
    if (fpu_rsp_valid && !flush)
      check("rsp_data", 256'(rsp), 256'({out_res, out_st, out_tag[TW-IW-1:0]}));
    rhs = fpu_rsp_valid && !flush && rsp_ready[ridx];

    ebusy = v;
    for (int i = 0; i < N; i++) if (cnt[i] > 0) ebusy = 1;
    check("busy", 256'(busy), 256'(ebusy));

    if (flush) begin
      for (int i = 0; i < N; i++) cnt[i] = 0;
      ptr = 0;
      locked = 0;
      fq.delete();
      shown = 0;
    end else begin
      if (rhs) begin
        cnt[ridx]--;
        void'(fq.pop_front());
        shown = 0;
      end
      if (hs) begin
        cnt[g]++;
        ptr = (g + 1) % N;
        locked = 0;
        done[g] = 1;
        fq.push_back({IW'(g), req[g].tag});
      end else if (v) begin
        locked = 1;
        lock_idx = g;
      end
    end
  endtask

  // Drive the next cycle's inputs just after the rising edge.
  task automatic drive();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (done[i]) begin
        req_valid[i] = 1'b0;
        done[i] = 0;
      end
      if (!req_valid[i] && chance(p_req)) begin
        req[i] = rand_req();
        req_valid[i] = 1'b1;
      end
      rsp_ready[i] = chance(p_rsp_rdy);
    end
    fpu_ready = chance(p_rdy);
    if (!shown && fq.size() > 0 && chance(p_rsp)) begin
      shown   = 1;
      out_tag = fq[0];
      out_res = {$urandom(), $urandom()};
      out_st  = status_t'(5'($urandom()));
    end
    if (!shown) out_tag = TW'($urandom());
    fpu_rsp_valid = shown;
    flush = chance(p_flush);
  endtask

  task automatic run_phase(input int cycles, input int pr, input int pf, input int ps,
                           input int psr, input int pfl);
    p_req = pr; p_rdy = pf; p_rsp = ps; p_rsp_rdy = psr; p_flush = pfl;
    repeat (cycles) begin
      step();
      drive();
    end
  endtask

  task automatic quiet_inputs();
    req_valid = '0;
    rsp_ready = '0;
    fpu_ready = 1'b0;
    fpu_rsp_valid = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < N; i++) done[i] = 0;
  endtask

  task automatic check_idle(input string name);
    check({name, "_busy"}, 256'(busy), 256'(0));
    check({name, "_fpu_valid"}, 256'(fpu_valid), 256'(0));
    check({name, "_req_ready"}, 256'(req_ready), 256'(0));
    check({name, "_rsp_valid"}, 256'(rsp_valid), 256'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0;
    out_res = '0;
    out_st = '0;
    out_tag = '0;
    quiet_inputs();
    model_clear();
    #1;
    check_idle("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive();

    // All requesters busy, FPU always ready, no results: strict rotation until every credit is used.
    run_phase(24, 100, 100, 0, 100, 0);
    // Backpressure on both sides exercises grant locking and response holding.
    run_phase(400, 60, 40, 50, 50, 0);
    // High throughput: issue and response often land on the same requester together.
    run_phase(300, 80, 95, 90, 90, 0);
    // Occasional flushes with traffic in flight.
    run_phase(300, 70, 60, 60, 60, 4);

    // Asynchronous reset while ops are outstanding.
    @(negedge clk);
    #2;
    quiet_inputs();
    rst_n = 1'b0;
    #1;
    check_idle("midreset");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    drive();

    run_phase(300, 70, 30, 30, 40, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
